// File: rtl/audio_pwm_out.sv
// Audio output stage: sample-rate strobe, ramped attenuation and 8-bit PWM.
// Volume and mute changes move one attenuation level per sample.
module audio_pwm_out #(
  parameter int CYCLES_PER_SAMPLE = 8334
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] amp_in,
  input  logic [2:0] volume_in,
  input  logic       mute_in,
  output logic       step_out,
  output logic       pwm_out,
  output logic [3:0] level_out,
  output logic       muted_out
);

  localparam logic [15:0] LAST = 16'(CYCLES_PER_SAMPLE - 1);

  localparam logic [1:0] S_MUTED = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DOWN  = 2'd2;
  localparam logic [1:0] S_UP    = 2'd3;

  logic [15:0]       cnt_q, cnt_d;
  logic              step_d1_q, step_d2_q;
  logic signed [7:0] sample_q;
  logic [3:0]        atten_q, atten_d;
  logic [1:0]        state_q, state_d;
  logic              muted_q;
  logic [7:0]        pcnt_q;
  logic [7:0]        duty_q;
  logic              pwm_q;

  logic              step;
  logic [3:0]        target;
  logic signed [7:0] scaled;
  logic [7:0]        duty;

  always_comb begin
    step    = (cnt_q == LAST);
    cnt_d   = step ? 16'd0 : cnt_q + 16'd1;
    target  = mute_in ? 4'd8 : {1'b0, volume_in};
    atten_d = atten_q;
    state_d = state_q;
    if (step) begin
      if (atten_q < target)
        atten_d = atten_q + 4'd1;
      else if (atten_q > target)
        atten_d = atten_q - 4'd1;
      if (atten_d == target)
        state_d = (target == 4'd8) ? S_MUTED : S_RUN;
      else if (atten_d < target)
        state_d = S_DOWN;
      else
        state_d = S_UP;
    end
  end

  // Adding 128 to a signed byte is just flipping its sign bit.
  always_comb begin
    scaled = atten_q[3] ? 8'sd0 : (sample_q >>> atten_q[2:0]);
    duty   = {~scaled[7], scaled[6:0]};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q     <= 16'd0;
      step_d1_q <= 1'b0;
      step_d2_q <= 1'b0;
      sample_q  <= 8'sd0;
      atten_q   <= 4'd8;
      state_q   <= S_MUTED;
      muted_q   <= 1'b1;
      pcnt_q    <= 8'd0;
      duty_q    <= 8'd128;
      pwm_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      step_d1_q <= step;
      step_d2_q <= step_d1_q;
      if (step_d2_q)
        sample_q <= amp_in;
      atten_q   <= atten_d;
      state_q   <= state_d;
      muted_q   <= (state_d == S_MUTED);
      pcnt_q    <= pcnt_q + 8'd1;
      if (pcnt_q == 8'hFF)
        duty_q <= duty;
      pwm_q     <= (pcnt_q < duty_q);
    end
  end

  assign step_out  = step;
  assign pwm_out   = pwm_q;
  assign level_out = atten_q;
  assign muted_out = muted_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Scoreboard bench for audio_pwm_out at 16 clocks per sample.
// Levels and PWM duty are predicted by the bench and compared when observed.
module tb_audio_pwm_out;

  localparam int CPS = 16;

  logic              clk;
  logic              rst;
  logic signed [7:0] amp;
  logic [2:0]        vol;
  logic              mute;
  logic              step_out;
  logic              pwm_out;
  logic [3:0]        level_out;
  logic              muted_out;

  int checks;
  int failures;
  int model_atten;
  int exp_level_q[$];
  bit exp_muted_q[$];
  int exp_duty_q[$];

  audio_pwm_out #(.CYCLES_PER_SAMPLE(CPS)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .amp_in   (amp),
    .volume_in(vol),
    .mute_in  (mute),
    .step_out (step_out),
    .pwm_out  (pwm_out),
    .level_out(level_out),
    .muted_out(muted_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic wait_step(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * CPS; i++) begin
      @(negedge clk);
      if (step_out) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called in the step cycle; predicts the level seen after the edge.
  task automatic model_step();
    int tgt;
    tgt = mute ? 8 : int'(vol);
    if (model_atten < tgt) model_atten++;
    else if (model_atten > tgt) model_atten--;
    exp_level_q.push_back(model_atten);
    exp_muted_q.push_back(model_atten == 8 && tgt == 8);
  endtask

  task automatic do_step();
    bit ok;
    wait_step(ok);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL step_timeout: no step_out within %0d cycles", 3 * CPS);
    end
    model_step();
    @(negedge clk);
  endtask

  task automatic measure_duty(output int cnt);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      cnt += int'(pwm_out);
    end
  endtask

  task automatic check_latency(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 3 * CPS; i++) begin
      @(negedge clk);
      n++;
      if (step_out) break;
    end
    checks++;
    if (n !== CPS - 1 || step_out !== 1'b1) begin
      failures++;
      $display("FAIL %s: first step after %0d cycles (step=%b), want %0d",
               name, n, step_out, CPS - 1);
    end
    checks++;
    if (muted_out !== 1'b1) begin
      failures++;
      $display("FAIL %s_muted_pre: muted=%b want 1", name, muted_out);
    end
  endtask

  task automatic run_steps(input string name, input int n);
    int el;
    bit em;
    for (int k = 0; k < n; k++) begin
      do_step();
      el = exp_level_q.pop_front();
      em = exp_muted_q.pop_front();
      checks++;
      if (level_out !== 4'(el)) begin
        failures++;
        $display("FAIL %s_level[%0d]: got %0d want %0d", name, k, level_out, el);
      end
      checks++;
      if (muted_out !== em) begin
        failures++;
        $display("FAIL %s_muted[%0d]: got %b want %b", name, k, muted_out, em);
      end
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    amp  = 8'sd0;
    vol  = 3'd0;
    mute = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (step_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_step: got %b want 0", step_out);
    end
    if (pwm_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_pwm: got %b want 0", pwm_out);
    end
    if (level_out !== 4'd8) begin
      failures++;
      $display("FAIL reset_level: got %0d want 8", level_out);
    end
    if (muted_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_muted: got %b want 1", muted_out);
    end
    rst = 1'b0;
    model_atten = 8;
    check_latency("reset_latency");
  endtask

  // Entered in the first step cycle after reset release.
  task automatic test_ramp_up();
    int el;
    bit em;
    model_step();
    @(negedge clk);
    el = exp_level_q.pop_front();
    em = exp_muted_q.pop_front();
    checks += 2;
    if (level_out !== 4'(el)) begin
      failures++;
      $display("FAIL ramp_first_level: got %0d want %0d", level_out, el);
    end
    if (muted_out !== em) begin
      failures++;
      $display("FAIL ramp_first_muted: got %b want %b", muted_out, em);
    end
    run_steps("ramp_up", 7);
  endtask

  task automatic test_duty();
    int tv_vol[5] = '{0, 0, 2, 7, 0};
    int tv_amp[5] = '{64, -128, -100, -1, 127};
    int s;
    int cnt;
    int ed;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vol = 3'(tv_vol[i]);
      amp = 8'(tv_amp[i]);
      s = tv_amp[i] >>> tv_vol[i];
      exp_duty_q.push_back(s + 128);
      repeat (700) @(negedge clk);
      model_atten = tv_vol[i];
      measure_duty(cnt);
      ed = exp_duty_q.pop_front();
      checks++;
      if (cnt !== ed) begin
        failures++;
        $display("FAIL duty[%0d] vol=%0d amp=%0d: high %0d of 256, want %0d",
                 i, tv_vol[i], tv_amp[i], cnt, ed);
      end
    end
  endtask

  task automatic test_mute();
    int cnt;
    int ed;
    amp  = 8'sd64;
    mute = 1'b1;
    run_steps("mute_down", 8);
    exp_duty_q.push_back(128);
    repeat (300) @(negedge clk);
    measure_duty(cnt);
    ed = exp_duty_q.pop_front();
    checks++;
    if (cnt !== ed) begin
      failures++;
      $display("FAIL mute_duty: high %0d of 256, want %0d", cnt, ed);
    end
    mute = 1'b0;
    run_steps("unmute_up", 8);
  endtask

  task automatic test_reversal();
    mute = 1'b1;
    run_steps("rev_down", 3);
    mute = 1'b0;
    run_steps("rev_up", 3);
  endtask

  task automatic test_frame();
    int c1;
    int c2;
    int e1;
    int e2;
    bit prev;
    bit found;
    amp = 8'sd0;
    repeat (300) @(negedge clk);
    exp_duty_q.push_back(128);
    exp_duty_q.push_back(192);
    found = 1'b0;
    prev = pwm_out;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!prev && pwm_out) begin
        found = 1'b1;
        break;
      end
      prev = pwm_out;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL frame_sync: no pwm rising edge in 600 cycles");
    end
    c1 = int'(pwm_out);
    for (int i = 1; i < 256; i++) begin
      @(negedge clk);
      if (i == 50) amp = 8'sd64;
      c1 += int'(pwm_out);
    end
    measure_duty(c2);
    e1 = exp_duty_q.pop_front();
    e2 = exp_duty_q.pop_front();
    checks += 2;
    if (c1 !== e1) begin
      failures++;
      $display("FAIL frame_old_duty: high %0d of 256, want %0d", c1, e1);
    end
    if (c2 !== e2) begin
      failures++;
      $display("FAIL frame_new_duty: high %0d of 256, want %0d", c2, e2);
    end
  endtask

  task automatic test_reset_mid();
    mute = 1'b1;
    run_steps("pre_rst", 3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 4;
    if (level_out !== 4'd8) begin
      failures++;
      $display("FAIL midrst_level: got %0d want 8", level_out);
    end
    if (muted_out !== 1'b1) begin
      failures++;
      $display("FAIL midrst_muted: got %b want 1", muted_out);
    end
    if (step_out !== 1'b0) begin
      failures++;
      $display("FAIL midrst_step: got %b want 0", step_out);
    end
    if (pwm_out !== 1'b0) begin
      failures++;
      $display("FAIL midrst_pwm: got %b want 0", pwm_out);
    end
    mute = 1'b0;
    vol  = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    model_atten = 8;
    check_latency("midrst_latency");
    test_ramp_up();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_ramp_up();
    test_duty();
    test_mute();
    test_reversal();
    test_frame();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
